// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared FSM encoding, master IDs and request bundle for the memory arbiter
package mem_arbiter_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;
  localparam logic M0_ID = 1'b0;
  localparam logic M1_ID = 1'b1;
  typedef struct packed {
    logic [3:0]  wstb;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;
endpackage

// File: rtl/mem_arbiter_rr.sv
// mem_arbiter_rr: combinational 2-way round-robin picker
//  req  in  2  request vector {M1, M0}
//  last in  1  master served most recently
//  hit  out 1  any request present
//  gnt  out 1  chosen master (meaningful only when hit)
module mem_arbiter_rr (
  input  logic [1:0] req,
  input  logic       last,
  output logic       hit,
  output logic       gnt
);
  assign hit = |req;
  assign gnt = &req ? ~last : req[1];
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-master round-robin arbiter onto one VALID/READY memory port with timeout abort
//  CLK, RST_N            clock, async active-low reset
//  Mx_VALID/WSTB/ADDR/WDATA  master requests (x = 0, 1), held until Mx_READY
//  Mx_READY/RDATA        one-cycle completion pulse and read data (0 when not ready)
//  S_VALID/WSTB/ADDR/WDATA   one-cycle slave request pulse, fields 0 when idle
//  S_READY/RDATA         slave completion and read data
//  ERR                   one-cycle pulse when a transaction is aborted by timeout
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        M0_VALID,
  input  logic [3:0]  M0_WSTB,
  input  logic [31:0] M0_ADDR,
  input  logic [31:0] M0_WDATA,
  output logic        M0_READY,
  output logic [31:0] M0_RDATA,
  input  logic        M1_VALID,
  input  logic [3:0]  M1_WSTB,
  input  logic [31:0] M1_ADDR,
  input  logic [31:0] M1_WDATA,
  output logic        M1_READY,
  output logic [31:0] M1_RDATA,
  output logic        S_VALID,
  output logic [3:0]  S_WSTB,
  output logic [31:0] S_ADDR,
  output logic [31:0] S_WDATA,
  input  logic        S_READY,
  input  logic [31:0] S_RDATA,
  output logic        ERR
);
  localparam int CW = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  state_t state, state_nx;
  logic gnt, gnt_nx, last, last_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [1:0] rr_req;
  logic rr_hit, rr_gnt, done;
  req_t sel;
  // At WAIT exit the completing master is masked so only the other one can be re-granted.
  assign rr_req = state == ST_WAIT ? {M1_VALID, M0_VALID} & ~(2'b01 << gnt) : {M1_VALID, M0_VALID};
  mem_arbiter_rr u_rr (
    .req  (rr_req),
    .last (last),
    .hit  (rr_hit),
    .gnt  (rr_gnt)
  );
  assign done = state == ST_WAIT && (S_READY || cnt == CNT_LAST);
  always_comb begin
    state_nx = state;
    gnt_nx   = gnt;
    last_nx  = last;
    cnt_nx   = cnt;
    unique case (state)
      ST_IDLE: begin
        state_nx = rr_hit ? ST_ISSUE : ST_IDLE;
        gnt_nx   = rr_hit ? rr_gnt : gnt;
      end
      ST_ISSUE: begin
        state_nx = ST_WAIT;
        cnt_nx   = '0;
      end
      ST_WAIT: begin
        state_nx = done ? (rr_hit ? ST_ISSUE : ST_IDLE) : ST_WAIT;
        gnt_nx   = done && rr_hit ? rr_gnt : gnt;
        last_nx  = done ? gnt : last;
        cnt_nx   = done ? cnt : cnt + CW'(1);
      end
      default: state_nx = ST_IDLE;
    endcase
  end
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= ST_IDLE;
      gnt   <= M0_ID;
      last  <= M1_ID;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      gnt   <= gnt_nx;
      last  <= last_nx;
      cnt   <= cnt_nx;
    end
  end
  assign sel      = gnt == M1_ID ? {M1_WSTB, M1_ADDR, M1_WDATA} : {M0_WSTB, M0_ADDR, M0_WDATA};
  assign S_VALID  = state == ST_ISSUE;
  assign S_WSTB   = S_VALID ? sel.wstb : '0;
  assign S_ADDR   = S_VALID ? sel.addr : '0;
  assign S_WDATA  = S_VALID ? sel.wdata : '0;
  assign ERR      = done && !S_READY;
  assign M0_READY = done && gnt == M0_ID;
  assign M1_READY = done && gnt == M1_ID;
  // On a timeout abort S_READY is low, so read data falls to 0 as well.
  assign M0_RDATA = M0_READY && S_READY ? S_RDATA : '0;
  assign M1_RDATA = M1_READY && S_READY ? S_RDATA : '0;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench with memory slave stub and abstract reference memory
module tb_mem_arbiter;
  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  logic [1:0] m_valid = 2'b00;
  logic [3:0] m_wstb [2] = '{4'h0, 4'h0};
  logic [31:0] m_addr [2] = '{32'h0, 32'h0};
  logic [31:0] m_wdata [2] = '{32'h0, 32'h0};
  logic m0_ready, m1_ready, err;
  logic [31:0] m0_rdata, m1_rdata;
  logic s_valid, s_ready;
  logic [3:0] s_wstb;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic s_rdy_q = 1'b0;
  logic [31:0] s_rdata_q = 32'h0;
  logic hang = 1'b0, force_rdy = 1'b0, chk_alt = 1'b0;
  int errors = 0, checks = 0, cyc = 0;
  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;
  exp_t q0[$], q1[$];
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] smem [logic [31:0]];

  mem_arbiter #(.TIMEOUT(16)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .M0_VALID(m_valid[0]), .M0_WSTB(m_wstb[0]), .M0_ADDR(m_addr[0]), .M0_WDATA(m_wdata[0]),
    .M0_READY(m0_ready), .M0_RDATA(m0_rdata),
    .M1_VALID(m_valid[1]), .M1_WSTB(m_wstb[1]), .M1_ADDR(m_addr[1]), .M1_WDATA(m_wdata[1]),
    .M1_READY(m1_ready), .M1_RDATA(m1_rdata),
    .S_VALID(s_valid), .S_WSTB(s_wstb), .S_ADDR(s_addr), .S_WDATA(s_wdata),
    .S_READY(s_ready), .S_RDATA(s_rdata), .ERR(err)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] s);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  function automatic logic rdy(input int m);
    return m == 1 ? m1_ready : m0_ready;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk(name, {31'b0, act}, {31'b0, exp});
  endtask

  // Memory slave stub: READY is a registered copy of VALID; RDATA is junk unless READY.
  initial forever begin
    logic [31:0] cur;
    @(posedge CLK or negedge RST_N);
    if (!RST_N) s_rdy_q <= 1'b0;
    else begin
      s_rdy_q <= s_valid && !hang;
      if (s_valid && !hang) begin
        cur = smem.exists(s_addr) ? smem[s_addr] : 32'h0;
        if (s_wstb != 4'h0) begin
          smem[s_addr] = merge(cur, s_wdata, s_wstb);
          s_rdata_q <= 32'h0;
        end else s_rdata_q <= cur;
      end
    end
  end
  assign s_ready = s_rdy_q | force_rdy;
  assign s_rdata = s_rdy_q ? s_rdata_q : 32'hBAD0_0BAD;

  // Monitor: pops expectations whenever a master sees READY, plus protocol invariants.
  initial begin
    bit prev_sv = 0, have_prev = 0;
    int prev_m = 0, prev_cyc = 0, cur_m;
    exp_t e;
    forever begin
      @(negedge CLK);
      if (!RST_N) begin
        prev_sv = 0;
        have_prev = 0;
        continue;
      end
      if (s_valid) chk1("s_valid_single_cycle", prev_sv, 1'b0);
      else chk("s_wstb_idle", {28'b0, s_wstb}, 32'h0);
      if (!chk_alt) have_prev = 0;
      if (m0_ready || m1_ready) begin
        chk1("two_readys", m0_ready && m1_ready, 1'b0);
        if (chk_alt) begin
          cur_m = m1_ready ? 1 : 0;
          if (have_prev) begin
            chk("rr_gap", 32'(cyc - prev_cyc), 32'd2);
            chk("rr_alternate", 32'(cur_m), 32'(1 - prev_m));
          end
          have_prev = 1;
          prev_m = cur_m;
          prev_cyc = cyc;
        end
      end else chk1("err_without_ready", err, 1'b0);
      if (m0_ready) begin
        if (q0.size() == 0) chk1("m0_unexpected_ready", m0_ready, 1'b0);
        else begin
          e = q0.pop_front();
          chk("m0_rdata", m0_rdata, e.rdata);
          chk1("m0_err", err, e.err);
        end
      end else chk("m0_rdata_idle", m0_rdata, 32'h0);
      if (m1_ready) begin
        if (q1.size() == 0) chk1("m1_unexpected_ready", m1_ready, 1'b0);
        else begin
          e = q1.pop_front();
          chk("m1_rdata", m1_rdata, e.rdata);
          chk1("m1_err", err, e.err);
        end
      end else chk("m1_rdata_idle", m1_rdata, 32'h0);
      prev_sv = s_valid;
    end
  end

  // One master transaction; expectation comes from the reference memory, not the DUT.
  task automatic req(input int m, input logic [3:0] wstb, input logic [31:0] addr,
                     input logic [31:0] wdata, input int exp_lat);
    exp_t e;
    int start;
    logic [31:0] cur;
    cur = ref_mem.exists(addr) ? ref_mem[addr] : 32'h0;
    e.err = hang;
    e.rdata = (hang || wstb != 4'h0) ? 32'h0 : cur;
    if (!hang && wstb != 4'h0) ref_mem[addr] = merge(cur, wdata, wstb);
    if (m == 1) q1.push_back(e); else q0.push_back(e);
    m_valid[m] = 1'b1;
    m_wstb[m] = wstb;
    m_addr[m] = addr;
    m_wdata[m] = wdata;
    start = cyc;
    do @(negedge CLK); while (!rdy(m) && cyc - start < 100);
    if (!rdy(m)) chk($sformatf("m%0d_ready_timeout", m), 32'(cyc - start), 32'(exp_lat));
    else if (exp_lat >= 0) chk($sformatf("m%0d_latency", m), 32'(cyc - start), 32'(exp_lat));
    @(posedge CLK);
    #1;
    m_valid[m] = 1'b0;
    m_wstb[m] = 4'h0;
  endtask

  task automatic sync;
    @(posedge CLK);
    #1;
  endtask

  task automatic rnd_req(input int m);
    req(m, $urandom_range(0, 1) ? 4'($urandom_range(1, 15)) : 4'h0,
        (m == 1 ? 32'h2000 : 32'h1000) + 32'(4 * $urandom_range(0, 15)), $urandom, -1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int n;
    #2;
    chk1("rst_s_valid", s_valid, 1'b0);
    chk1("rst_m0_ready", m0_ready, 1'b0);
    chk1("rst_m1_ready", m1_ready, 1'b0);
    chk1("rst_err", err, 1'b0);
    chk("rst_s_addr", s_addr, 32'h0);
    chk("rst_m0_rdata", m0_rdata, 32'h0);
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    // Reset asserted mid-WAIT while READY is being presented
    hang = 1'b1;
    sync();
    m_valid[0] = 1'b1;
    m_addr[0] = 32'h100;
    repeat (5) @(negedge CLK);
    #1 force_rdy = 1'b1;
    #1 chk1("wait_ready_before_reset", m0_ready, 1'b1);
    #1 RST_N = 1'b0;
    #1;
    chk1("async_m0_ready", m0_ready, 1'b0);
    chk1("async_m1_ready", m1_ready, 1'b0);
    chk1("async_err", err, 1'b0);
    chk1("async_s_valid", s_valid, 1'b0);
    chk("async_m0_rdata", m0_rdata, 32'h0);
    force_rdy = 1'b0;
    hang = 1'b0;
    m_valid[0] = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
    // Reset asserted while S_VALID is high
    sync();
    m_valid[0] = 1'b1;
    n = 0;
    do begin @(negedge CLK); n++; end while (!s_valid && n < 10);
    chk1("issue_seen", s_valid, 1'b1);
    #1 RST_N = 1'b0;
    #1;
    chk1("issue_async_s_valid", s_valid, 1'b0);
    chk("issue_async_s_addr", s_addr, 32'h0);
    m_valid[0] = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
    // Write then read back, idle latency 2
    sync();
    req(0, 4'hF, 32'h100, 32'hDEADBEEF, 2);
    req(0, 4'h0, 32'h100, 32'h0, 2);
    // Simultaneous requests right after reset: M0 first, M1 issued straight after
    @(negedge CLK);
    RST_N = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
    sync();
    fork
      req(0, 4'h0, 32'h100, 32'h0, 2);
      req(1, 4'hF, 32'h2100, 32'hCAFE0001, 4);
    join
    // Continuous contention: strict alternation, one READY every 2 cycles
    chk_alt = 1'b1;
    fork
      for (int i = 0; i < 4; i++) rnd_req(0);
      for (int i = 0; i < 4; i++) rnd_req(1);
    join
    chk_alt = 1'b0;
    // Slave never answers: abort 16 cycles after S_VALID
    hang = 1'b1;
    req(0, 4'h0, 32'h100, 32'h0, 17);
    hang = 1'b0;
    // Byte-lane write merge
    req(0, 4'hF, 32'h300, 32'h11223344, 2);
    req(0, 4'b0100, 32'h300, 32'h00AB0000, 2);
    req(0, 4'h0, 32'h300, 32'h0, 2);
    // Random traffic with random gaps
    fork
      for (int i = 0; i < 12; i++) begin
        repeat ($urandom_range(0, 3)) @(posedge CLK);
        #1 rnd_req(0);
      end
      for (int i = 0; i < 12; i++) begin
        repeat ($urandom_range(0, 3)) @(posedge CLK);
        #1 rnd_req(1);
      end
    join
    repeat (4) @(negedge CLK);
    chk("scoreboard_drained", 32'(q0.size() + q1.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
